// File: rtl/plot_sink.sv
// plot_sink: captures vga_plot strobes into a small FIFO and turns each one
// into a linear framebuffer write (addr = y*H_RES + x) using a we/ready handshake.
// Optional feature: define PLOT_SINK_CLIP_EN to discard strobes whose
// coordinates fall outside H_RES x V_RES.
module plot_sink #(
  parameter int unsigned H_RES  = 320,
  parameter int unsigned V_RES  = 240,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8:0]        vga_x,
  input  logic [7:0]        vga_y,
  input  logic [2:0]        vga_colour,
  input  logic              vga_plot,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [19:0]         fifo_q [DEPTH];
  logic [PW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          wdata_q, wdata_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         drop_q, drop_d;

  logic                empty, full, clip, push, pop, drop;
  logic [19:0]         head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head  = fifo_q[rd_ptr_q[PW-1:0]];

`ifdef PLOT_SINK_CLIP_EN
  assign clip = (32'(vga_x) >= H_RES) || (32'(vga_y) >= V_RES);
`else
  assign clip = 1'b0;
`endif

  // Push/drop decision uses pre-edge occupancy; a full FIFO drops even if it pops this edge.
  assign push = vga_plot && !flush && !full && !clip;
  assign drop = vga_plot && !flush && (full || clip);

  // Output FSM, FIFO pointers, status counters: next-state logic
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          if (!empty) pop = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      addr_d  = ADDR_W'(head[10:3]) * ADDR_W'(H_RES) + ADDR_W'(head[19:11]);
      wdata_d = head[2:0];
    end
    if (drop) begin
      if (!clip) ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 16'd1;
    end
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    if (flush) begin
      state_d  = S_IDLE;
      pop      = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= {vga_x, vga_y, vga_colour};
  end

  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = !empty || mem_we;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: directed scenarios followed by random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_plot_sink;

  localparam int unsigned H  = 320;
  localparam int unsigned V  = 240;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [8:0]    vga_x;
  logic [7:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;
  logic          flush;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_wdata;
  logic          mem_we;
  logic          mem_ready;
  logic          busy;
  logic          overflow;
  logic [15:0]   drop_count;

  plot_sink #(.H_RES(H), .V_RES(V), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .flush(flush),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [2:0]  c;
  } pix_t;

  // Reference model: queued pixels plus the pixel currently offered to memory.
  pix_t        mq[$];
  pix_t        m_held;
  bit          m_valid;
  bit          m_ovf;
  int unsigned m_drop;
  int unsigned m_writes;
  int unsigned dut_writes;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_valid = 0;
    m_ovf   = 0;
    m_drop  = 0;
  endtask

  task automatic check_all();
    chk("mem_we", 32'(mem_we), 32'(m_valid));
    if (m_valid) begin
      chk("mem_addr", 32'(mem_addr), m_held.addr);
      chk("mem_wdata", 32'(mem_wdata), 32'(m_held.c));
    end
    chk("busy", 32'(busy), 32'(m_valid || mq.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), m_drop);
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, check at next negedge.
  task automatic cyc(input bit plot, input int unsigned x, input int unsigned y,
                     input logic [2:0] c, input bit rdy, input bit fl);
    bit   full, clipped;
    pix_t p;
    vga_plot   = plot;
    vga_x      = x[8:0];
    vga_y      = y[7:0];
    vga_colour = c;
    mem_ready  = rdy;
    flush      = fl;
    #1;
    if (mem_we && mem_ready) dut_writes++;
    @(posedge clk);
    if (m_valid && rdy) m_writes++;
    if (fl) begin
      model_clear();
    end else begin
      full = (mq.size() == D);
      if (!m_valid || rdy) begin
        if (mq.size() > 0) begin
          m_held  = mq.pop_front();
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      if (plot) begin
`ifdef PLOT_SINK_CLIP_EN
        clipped = (x >= H) || (y >= V);
`else
        clipped = 0;
`endif
        if (clipped || full) begin
          if (!clipped) m_ovf = 1;
          if (m_drop < 32'hFFFF) m_drop++;
        end else begin
          p.addr = (y * H + x) % (32'd1 << AW);
          p.c    = c;
          mq.push_back(p);
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int unsigned n, input bit rdy);
    for (int i = 0; i < int'(n); i++) cyc(0, 0, 0, 3'd0, rdy, 0);
  endtask

  int unsigned w0;

  initial begin
    m_writes = 0;
    dut_writes = 0;
    model_clear();
    vga_plot = 0; vga_x = '0; vga_y = '0; vga_colour = '0;
    flush = 0; mem_ready = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rst_n = 1;

    // Single plot: one cycle latency, addr 2*320+5
    cyc(1, 5, 2, 3'b111, 1, 0);
    chk("t1_latency_we", 32'(mem_we), 0);
    cyc(0, 0, 0, 3'd0, 1, 0);
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_addr", 32'(mem_addr), 645);
    chk("t1_wdata", 32'(mem_wdata), 7);
    cyc(0, 0, 0, 3'd0, 1, 0);
    chk("t1_busy_after", 32'(busy), 0);

    // Eight back-to-back plots with memory always ready
    w0 = dut_writes;
    for (int i = 0; i < 8; i++) cyc(1, 10 + i, 20, 3'(i), 1, 0);
    idle(3, 1);
    chk("t2_writes", dut_writes - w0, 8);
    chk("t2_ovf", 32'(overflow), 0);

    // Stalled memory: 10 plots, the 10th hits a full FIFO
    w0 = dut_writes;
    for (int i = 0; i < 10; i++) cyc(1, i, 100, 3'(i), 0, 0);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_count), 1);
    idle(12, 1);
    chk("t3_writes", dut_writes - w0, 9);

    // Ready toggling during a 4-pixel burst
    cyc(0, 0, 0, 3'd0, 1, 1);
    w0 = dut_writes;
    for (int i = 0; i < 4; i++) cyc(1, 200 + i, 239, 3'(i + 2), (i % 2) == 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 3'd0, (i % 2) == 0, 0);
    chk("t4_writes", dut_writes - w0, 4);

    // Flush with pixels queued and a simultaneous plot
    for (int i = 0; i < 5; i++) cyc(1, i, 5, 3'd1, 0, 0);
    cyc(1, 7, 7, 3'd2, 0, 1);
    chk("t5_we", 32'(mem_we), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_drop", 32'(drop_count), 0);
    w0 = dut_writes;
    idle(4, 1);
    chk("t5_no_writes", dut_writes - w0, 0);

    // Out-of-range x
    w0 = dut_writes;
    cyc(1, 320, 0, 3'd5, 1, 0);
    cyc(0, 0, 0, 3'd0, 1, 0);
`ifdef PLOT_SINK_CLIP_EN
    chk("t6_we", 32'(mem_we), 0);
    chk("t6_drop", 32'(drop_count), 1);
    chk("t6_ovf", 32'(overflow), 0);
`else
    chk("t6_we", 32'(mem_we), 1);
    chk("t6_addr", 32'(mem_addr), 320);
`endif
    idle(2, 1);

    // Asynchronous reset while a write is pending
    cyc(1, 3, 3, 3'd3, 0, 0);
    cyc(1, 4, 3, 3'd3, 0, 0);
    chk("t7_we_before", 32'(mem_we), 1);
    #2 rst_n = 0;
    #1;
    chk("t7_we_async", 32'(mem_we), 0);
    chk("t7_busy_async", 32'(busy), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1;
    idle(3, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, $urandom % 330, $urandom % 250, 3'($urandom),
          ($urandom % 3) != 0, ($urandom % 60) == 0);
    idle(20, 1);
    chk("rand_writes", dut_writes, m_writes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
